// File: rtl/csa_tree_pkg.sv
// ---------------------------------------------------------------------------
// csa_tree_pkg
// Shared definitions for the CSA tree front end: the packer state encoding
// and a helper that derives the tree depth from its lane count.
// No ports (package).
// ---------------------------------------------------------------------------
package csa_tree_pkg;

   localparam int DEF_DATA_W = 3;
   localparam int DEF_DATA_N = 8;

   // Number of reduction levels the tree needs to fold n lanes down to one
   // result when each level halves the lane count (rounding up).
   function automatic int StageCount(input int n);
      int stages;
      int lanes;
      stages = 0;
      lanes  = n;
      while (lanes > 1) begin
         lanes  = (lanes + 1) / 2;
         stages = stages + 1;
      end
      return stages;
   endfunction

   // FILL collects words of a frame, FULL holds a completed frame that the
   // downstream has not yet allowed us to load.
   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } pack_state_t;

endpackage

// File: rtl/csa_valid_delay.sv
// ---------------------------------------------------------------------------
// csa_valid_delay
// Fixed-depth shift register that carries the per-frame tag alongside the
// tree pipeline so the tag emerges exactly when the tree's sum does.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, flushes all in-flight tags
//   din    in   WIDTH-bit tag entering the pipeline
//   dout   out  WIDTH-bit tag leaving the pipeline DEPTH cycles later
// ---------------------------------------------------------------------------
module csa_valid_delay
   import csa_tree_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe [DEPTH];

   // Each tag moves one stage per clock; reset empties every stage so no
   // stale tag can ever surface after a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pipe[i] <= '0;
         end
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/csa_tree_packer.sv
// ---------------------------------------------------------------------------
// csa_tree_packer
// Front end for the pipelined CSA tree. Collects a word-serial valid/ready
// stream into an I_DATA_N-lane frame (lane 0 = first word), loads the frame
// onto the tree inputs, and flags when the tree output holds that frame's sum.
// A word with s_last closes a short frame; unused lanes are zero.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   s_valid      in   input word valid
//   s_ready      out  input word accepted when s_valid & s_ready
//   s_data       in   input word
//   s_last       in   word closes the frame
//   m_stall      in   downstream forbids loading a new frame this cycle
//   o_data       out  packed frame driving the tree inputs
//   o_load       out  one-cycle pulse, o_data holds a new frame
//   o_sum_valid  out  tree output holds the sum of the frame loaded TREE_LAT ago
//   o_sum_last   out  that frame was closed by s_last
// ---------------------------------------------------------------------------
module csa_tree_packer
   import csa_tree_pkg::*;
#(
   parameter int I_DATA_W = DEF_DATA_W,
   parameter int I_DATA_N = DEF_DATA_N,
   parameter int TREE_LAT = StageCount(I_DATA_N) + 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   input  logic [I_DATA_W-1:0]                  s_data,
   input  logic                                 s_last,
   input  logic                                 m_stall,
   output logic [0:I_DATA_N-1][I_DATA_W-1:0]    o_data,
   output logic                                 o_load,
   output logic                                 o_sum_valid,
   output logic                                 o_sum_last
);

   localparam int CNT_W = (I_DATA_N > 1) ? $clog2(I_DATA_N) : 1;
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(I_DATA_N - 1);

   typedef logic [0:I_DATA_N-1][I_DATA_W-1:0] frame_t;

   pack_state_t      state;
   logic [CNT_W-1:0] count;
   frame_t           stage;
   frame_t           stage_with_word;
   frame_t           first_word_frame;
   logic             accept;
   logic             completes;
   logic             pend_last;
   logic             load_last;
   logic [1:0]       tag_out;

   // Input readiness depends only on the state and m_stall, never on s_valid,
   // so the upstream can't form a combinational loop through us. In FULL we
   // can take a word only in the cycle the held frame is released.
   assign s_ready   = (state == FILL) | ~m_stall;
   assign accept    = s_valid & s_ready;
   assign completes = (count == LAST_LANE) | s_last;

   // The staging lanes above the fill point are always zero (they are cleared
   // whenever a frame leaves), so dropping the current word into its lane
   // already yields the zero-padded frame.
   always_comb begin
      stage_with_word        = stage;
      stage_with_word[count] = s_data;
      first_word_frame       = '0;
      first_word_frame[0]    = s_data;
   end

   // Packer FSM, lane counter and staging lanes. o_data only changes on a
   // load so it holds the last frame in between. A word accepted in the
   // release cycle of FULL starts the next frame in lane 0; if that word
   // also closes a frame, it becomes the new held frame and we stay in FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         count     <= '0;
         stage     <= '0;
         o_data    <= '0;
         o_load    <= 1'b0;
         load_last <= 1'b0;
         pend_last <= 1'b0;
      end else begin
         o_load <= 1'b0;
         case (state)
            FILL: begin
               if (accept) begin
                  if (completes && !m_stall) begin
                     o_data    <= stage_with_word;
                     o_load    <= 1'b1;
                     load_last <= s_last;
                     stage     <= '0;
                     count     <= '0;
                  end else if (completes) begin
                     stage     <= stage_with_word;
                     pend_last <= s_last;
                     state     <= FULL;
                  end else begin
                     stage <= stage_with_word;
                     count <= count + CNT_W'(1);
                  end
               end
            end
            FULL: begin
               if (!m_stall) begin
                  o_data    <= stage;
                  o_load    <= 1'b1;
                  load_last <= pend_last;
                  stage     <= '0;
                  count     <= '0;
                  state     <= FILL;
                  if (accept) begin
                     stage <= first_word_frame;
                     if (s_last) begin
                        pend_last <= 1'b1;
                        state     <= FULL;
                     end else begin
                        count <= CNT_W'(1);
                     end
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // The frame tag travels TREE_LAT cycles behind o_load so it lines up with
   // the tree output; the last flag is only meaningful alongside a valid tag.
   csa_valid_delay #(
      .DEPTH (TREE_LAT),
      .WIDTH (2)
   ) u_valid_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({o_load, o_load & load_last}),
      .dout  (tag_out)
   );

   assign o_sum_valid = tag_out[1];
   assign o_sum_last  = tag_out[0];

endmodule

// File: tb/tb_csa_tree_packer.sv
// ---------------------------------------------------------------------------
// tb_csa_tree_packer
// Self-checking bench for csa_tree_packer. A frame-level model (queues of
// words and completed frames) predicts s_ready, every load with its frame
// contents, and every sum tag with its timing, last flag and frame sum.
// ---------------------------------------------------------------------------
module tb_csa_tree_packer;
   import csa_tree_pkg::*;

   localparam int W   = 3;
   localparam int N   = 8;
   localparam int LAT = 4;

   typedef logic [0:N-1][W-1:0] frame_t;
   typedef struct { frame_t data; bit last; } frame_rec_t;
   typedef struct { int cyc; int expSum; int obsSum; bit last; } sum_rec_t;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_last  = 1'b0;
   logic         m_stall = 1'b0;
   logic [W-1:0] s_data  = '0;
   logic         s_ready;
   logic         o_load;
   logic         o_sum_valid;
   logic         o_sum_last;
   frame_t       o_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   frame_rec_t   pendQ[$];
   logic [W-1:0] curWords[$];
   sum_rec_t     sumQ[$];
   bit           expLoad      = 1'b0;
   frame_t       expFrame     = '0;
   bit           expFrameLast = 1'b0;
   bit           trackB2B     = 1'b0;
   int           segLoads     = 0;
   int           lastLoadCyc  = -1;

   csa_tree_packer #(
      .I_DATA_W (W),
      .I_DATA_N (N),
      .TREE_LAT (LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .m_stall     (m_stall),
      .o_data      (o_data),
      .o_load      (o_load),
      .o_sum_valid (o_sum_valid),
      .o_sum_last  (o_sum_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int frameSum(input frame_t f);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += int'(f[i]);
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle of input drive, applied just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic l, input logic st);
      @(posedge clk);
      #1;
      s_valid = v;
      s_data  = d;
      s_last  = l;
      m_stall = st;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: at each falling edge compare the outputs produced by the last
   // rising edge, then advance the frame model with this cycle's inputs.
   always @(negedge clk) begin : monitor
      sum_rec_t   e;
      frame_rec_t f;
      frame_t     fr;
      bit         expSumValid;
      bit         expReady;
      if (!rst_n) begin
         checkOutput("reset_o_load",      32'(o_load),      32'd0);
         checkOutput("reset_o_data",      32'(o_data),      32'd0);
         checkOutput("reset_o_sum_valid", 32'(o_sum_valid), 32'd0);
         checkOutput("reset_o_sum_last",  32'(o_sum_last),  32'd0);
         checkOutput("reset_s_ready",     32'(s_ready),     32'd1);
         pendQ.delete();
         curWords.delete();
         sumQ.delete();
         expLoad = 1'b0;
      end else begin
         checkOutput("o_load", 32'(o_load), 32'(expLoad));
         if (expLoad) begin
            checkOutput("o_data", 32'(o_data), 32'(expFrame));
            e.cyc    = cyc;
            e.expSum = frameSum(expFrame);
            e.obsSum = frameSum(o_data);
            e.last   = expFrameLast;
            sumQ.push_back(e);
            if (trackB2B) begin
               segLoads++;
               if (lastLoadCyc >= 0) checkOutput("b2b_interval", 32'(cyc - lastLoadCyc), 32'd8);
               lastLoadCyc = cyc;
            end
         end
         expSumValid = (sumQ.size() > 0) && (sumQ[0].cyc + LAT == cyc);
         checkOutput("o_sum_valid", 32'(o_sum_valid), 32'(expSumValid));
         if (expSumValid) begin
            e = sumQ.pop_front();
            checkOutput("o_sum_last", 32'(o_sum_last), 32'(e.last));
            checkOutput("frame_sum",  32'(e.obsSum),   32'(e.expSum));
         end else begin
            checkOutput("o_sum_last_idle", 32'(o_sum_last), 32'd0);
         end
         expReady = (pendQ.size() == 0) || !m_stall;
         checkOutput("s_ready", 32'(s_ready), 32'(expReady));
         if (s_valid && expReady) begin
            curWords.push_back(s_data);
            if (curWords.size() == N || s_last) begin
               fr = '0;
               for (int i = 0; i < curWords.size(); i++) fr[i] = curWords[i];
               f.data = fr;
               f.last = s_last;
               pendQ.push_back(f);
               curWords.delete();
            end
         end
         expLoad = 1'b0;
         if (pendQ.size() > 0 && !m_stall) begin
            f            = pendQ.pop_front();
            expLoad      = 1'b1;
            expFrame     = f.data;
            expFrameLast = f.last;
         end
      end
   end

   initial begin
      int w1[8];
      $display("[TB] csa_tree_packer bench starting");
      w1 = '{1, 2, 3, 4, 5, 6, 7, 7};

      #2 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Full 8-word frame, no stall: sum 35, not last.
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(w1[i]), 1'b0, 1'b0);
      idleCycles(7);

      // Short frame of three 7s closed by s_last: sum 21, last.
      applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
      idleCycles(7);

      // Stall held for five cycles across frame completion, words offered
      // throughout; the release cycle's word must land in lane 0.
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 3'(i + 1), 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd7, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'd6, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'd6, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      idleCycles(7);

      // Back-to-back frames from 32 continuous random words.
      trackB2B    = 1'b1;
      segLoads    = 0;
      lastLoadCyc = -1;
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      idleCycles(8);
      trackB2B = 1'b0;
      checkOutput("b2b_load_count", 32'(segLoads), 32'd4);

      // Single-word frame closed on its first word.
      applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
      idleCycles(7);

      // Two sum tags in flight plus a partial frame, then a one-cycle reset.
      applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd4, 1'b1, 1'b0);
      applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_stall = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idleCycles(8);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0);
      idleCycles(8);

      // Mixed random traffic: gaps, stalls and short frames.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 3));
      end
      idleCycles(14);
      checkOutput("sum_queue_drained", 32'(sumQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
